// File: rtl/bias_ctrl_pkg.sv
// Shared state encoding and memory timing constants for the bias datapath controller.
package bias_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_EMIT,
        S_PASS,
        S_FIN
    } state_t;

    // Bias memory read latency; FETCH->LOAD spacing is built around this value.
    localparam int BIAS_RD_LAT = 1;

endpackage

// File: rtl/bias_ctrl.sv
// Sequences bias fetch/load/sum per output unit, or bypass; in_valid->out_en 1 cycle, ->out_valid 2 cycles.
// No backpressure: in_valid outside WAIT (bias) or PASS is dropped and flagged in sticky overrun.
module bias_ctrl
    import bias_ctrl_pkg::*;
#(
    parameter int AWIDTH = 10,
    parameter int CWIDTH = 10
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              start,
    input  logic              bias_on,
    input  logic [CWIDTH-1:0] total_out,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic              in_valid,
    output logic [AWIDTH-1:0] bias_addr,
    output logic              breg_we,
    output logic              enable,
    output logic              out_en,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    state_t            state;
    logic [CWIDTH-1:0] cnt;
    logic [CWIDTH-1:0] tot;
    logic [AWIDTH-1:0] base_q;
    logic [CWIDTH-1:0] cnt_inc;

    assign cnt_inc = cnt + CWIDTH'(1);

    always_ff @(posedge clk) begin
        if (xrst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tot       <= '0;
            base_q    <= '0;
            bias_addr <= '0;
            breg_we   <= 1'b0;
            enable    <= 1'b0;
            out_en    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            breg_we   <= 1'b0;
            out_en    <= 1'b0;
            done      <= 1'b0;
            // Bias mode: valid trails out_en; bypass: valid trails the input directly.
            out_valid <= out_en || (state == S_PASS && in_valid);

            // Any input the current state cannot consume is dropped and flagged.
            if (in_valid && state != S_WAIT && state != S_PASS)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        enable  <= bias_on;
                        tot     <= total_out;
                        base_q  <= base_addr;
                        cnt     <= '0;
                        overrun <= 1'b0;
                        busy    <= 1'b1;
                        if (total_out == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else if (bias_on) begin
                            state     <= S_FETCH;
                            bias_addr <= base_addr;
                        end else begin
                            state <= S_PASS;
                        end
                    end
                end
                S_FETCH: begin
                    state   <= S_LOAD;
                    breg_we <= 1'b1;
                end
                S_LOAD: state <= S_WAIT;
                S_WAIT: begin
                    if (in_valid) begin
                        state  <= S_EMIT;
                        out_en <= 1'b1;
                    end
                end
                S_EMIT: begin
                    cnt <= cnt_inc;
                    if (cnt_inc == tot) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end else begin
                        state     <= S_FETCH;
                        bias_addr <= base_q + AWIDTH'(cnt_inc);
                    end
                end
                S_PASS: begin
                    if (in_valid) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == tot) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
